// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, fetch buffer entry type and fetch FSM states
//   NOP_INSTR_DEF  addi x0,x0,0 driven when no fetched word is available
//   RESET_PC_DEF   default first fetch address after reset
package ifetch_pkg;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    typedef enum logic {ST_RUN, ST_DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO of fetched {pc, instr} words
//   clk_i, rst_i (async, active-low)
//   clear_i      empty the FIFO; dominates a same-cycle push
//   push_i       write push_data_i at the tail
//   pop_i        drop the head entry (caller guarantees non-empty)
//   head_o       head entry, combinational
//   count_o      occupancy, empty_o occupancy is zero
module fetch_buf
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wr <= wrap_inc(r_wr);
            if (pop_i) r_rd <= wrap_inc(r_rd);
            r_count <= r_count + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) r_mem[r_wr] <= push_data_i;
    end

    assign head_o  = r_mem[r_rd];
    assign count_o = r_count;
    assign empty_o = (r_count == '0);
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF/ID register
//   clk_i, rst_i (async, active-low)
//   stall_i, redirect_i, redirect_pc_i    hazard hold and branch/jump restart
//   imem_req_o/imem_addr_o/imem_ready_i   request channel (accept = req & ready)
//   imem_rvalid_i/imem_rdata_i            in-order response channel
//   valid_o, pc_o, pcplus4_o, instruction_o  head word presented to IF/ID
//   IFETCH_PERF_EN defined: adds perf_stall_cnt_o, perf_bubble_cnt_o,
//   perf_redirect_cnt_o saturating event counters
module if_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic [31:0] instruction_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_bubble_cnt_o,
    output logic [31:0] perf_redirect_cnt_o
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_kill;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_kill_nxt;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_used;
    logic [31:0]   w_redirect_pc;
    logic          w_empty;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    // r_resp_pc is the PC of the next response that will be kept: killed
    // responses never advance it, so it is reloaded with the target on redirect.
    assign w_push_entry  = '{pc: r_resp_pc, instr: imem_rdata_i};
    assign w_redirect_pc = redirect_pc_i & ~32'h3;
    assign imem_addr_o   = r_fetch_pc;

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (redirect_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .empty_o     (w_empty)
    );

    always_comb begin
        valid_o       = ~w_empty;
        pc_o          = valid_o ? w_head.pc : '0;
        pcplus4_o     = pc_o + 32'd4;
        instruction_o = valid_o ? w_head.instr : NOP_INSTR;
    end

    // Credit counts the slot freed by a same-cycle pop so a full-rate stream
    // needs no bubble; in-flight plus buffered words still never exceed BUF_DEPTH.
    always_comb begin
        w_pop          = valid_o & ~stall_i;
        w_used         = {1'b0, r_inflight} + {1'b0, w_count} - (CW+1)'(w_pop);
        imem_req_o     = rst_i & ~redirect_i & (w_used < (CW+1)'(BUF_DEPTH));
        w_accept       = imem_req_o & imem_ready_i;
        w_drop         = imem_rvalid_i & (r_state == ST_DRAIN);
        w_push         = imem_rvalid_i & ~w_drop;
        w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(imem_rvalid_i);
        w_kill_nxt     = redirect_i ? r_inflight - CW'(imem_rvalid_i) : r_kill - CW'(w_drop);
        w_state_nxt    = (w_kill_nxt != '0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_RUN;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_kill     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_kill     <= w_kill_nxt;
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_perf_stall    <= '0;
            r_perf_bubble   <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (stall_i && valid_o && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 32'd1;
            if (!stall_i && !valid_o && !(&r_perf_bubble)) r_perf_bubble <= r_perf_bubble + 32'd1;
            if (redirect_i && !(&r_perf_redirect)) r_perf_redirect <= r_perf_redirect + 32'd1;
        end
    end

    assign perf_stall_cnt_o    = r_perf_stall;
    assign perf_bubble_cnt_o   = r_perf_bubble;
    assign perf_redirect_cnt_o = r_perf_redirect;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit against a 1/2-cycle memory model
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        ready = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] instr;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_bubble;
    logic [31:0] perf_redir;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int lat = 1;
    logic        s1_v;
    logic        s2_v;
    logic [31:0] s1_a;
    logic [31:0] s2_a;
    logic [31:0] ra;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ready_i  (ready),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .valid_o       (valid),
        .pc_o          (pc),
        .pcplus4_o     (pcp4),
        .instruction_o (instr)
`ifdef IFETCH_PERF_EN
        ,
        .perf_stall_cnt_o    (perf_stall),
        .perf_bubble_cnt_o   (perf_bubble),
        .perf_redirect_cnt_o (perf_redir)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_a <= '0;
            s2_a <= '0;
        end else begin
            s1_v <= req & ready;
            s1_a <= addr;
            s2_v <= s1_v;
            s2_a <= s1_a;
        end
    end

    assign rvalid = (lat == 1) ? s1_v : s2_v;
    assign ra     = (lat == 1) ? s1_a : s2_a;
    assign rdata  = {16'hC0DE, ra[15:0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = l;
        stall = 1'b0;
        redir = 1'b0;
        ready = 1'b1;
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_pcp4"}, pcp4, 32'd4);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_req"}, {31'd0, req}, 32'd0);
    endtask

    initial begin
        #3;
        chk_reset("rst0");
        do_reset(1);
        #1 chk("a_req_c0", {31'd0, req}, 32'd1);
        chk("a_addr_c0", addr, 32'd0);
        nxt();
        #1 chk("a_valid_c1", {31'd0, valid}, 32'd0);
        nxt();
        for (int i = 2; i < 6; i++) begin
            #1 chk("a_valid", {31'd0, valid}, 32'd1);
            chk("a_pc", pc, 32'(4 * (i - 2)));
            chk("a_pcp4", pcp4, 32'(4 * (i - 1)));
            chk("a_instr", instr, 32'hC0DE_0000 | 32'(4 * (i - 2)));
            nxt();
        end
        stall = 1'b1;
        for (int i = 6; i < 11; i++) begin
            #1 chk("stall_pc", pc, 32'h10);
            chk("stall_req", {31'd0, req}, 32'd0);
            nxt();
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("resume_valid", {31'd0, valid}, 32'd1);
            chk("resume_pc", pc, 32'h10 + 32'(4 * i));
            nxt();
        end
        rst = 1'b0;
        #1 chk_reset("rst_mid");
        do_reset(2);
        nxt();
        nxt();
        redir = 1'b1;
        redir_pc = 32'h103;
        #1 chk("b_req_redir", {31'd0, req}, 32'd0);
        nxt();
        redir = 1'b0;
        #1 chk("b_valid_c3", {31'd0, valid}, 32'd0);
        chk("b_req_c3", {31'd0, req}, 32'd1);
        chk("b_addr_c3", addr, 32'h100);
        nxt();
        #1 chk("b_valid_c4", {31'd0, valid}, 32'd0);
        chk("b_addr_c4", addr, 32'h104);
        nxt();
        #1 chk("b_valid_c5", {31'd0, valid}, 32'd0);
        nxt();
        #1 chk("b_valid_c6", {31'd0, valid}, 32'd1);
        chk("b_pc_c6", pc, 32'h100);
        chk("b_pcp4_c6", pcp4, 32'h104);
        chk("b_instr_c6", instr, 32'hC0DE_0100);
        nxt();
        #1 chk("b_pc_c7", pc, 32'h104);
        do_reset(1);
        nxt();
        nxt();
        nxt();
        stall = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h200;
        #1 chk("c_req_redir", {31'd0, req}, 32'd0);
        chk("c_pc_c3", pc, 32'h4);
        chk("c_rvalid_c3", {31'd0, rvalid}, 32'd1);
        nxt();
        stall = 1'b0;
        redir = 1'b0;
        #1 chk("c_valid_c4", {31'd0, valid}, 32'd0);
        chk("c_addr_c4", addr, 32'h200);
        chk("c_req_c4", {31'd0, req}, 32'd1);
        nxt();
        #1 chk("c_valid_c5", {31'd0, valid}, 32'd0);
        nxt();
        #1 chk("c_valid_c6", {31'd0, valid}, 32'd1);
        chk("c_pc_c6", pc, 32'h200);
        chk("c_instr_c6", instr, 32'hC0DE_0200);
        do_reset(1);
        nxt();
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFF8;
        nxt();
        redir = 1'b0;
        ready = 1'b0;
        for (int i = 2; i < 5; i++) begin
            #1 chk("d_hold_req", {31'd0, req}, 32'd1);
            chk("d_hold_addr", addr, 32'hFFFF_FFF8);
            nxt();
        end
        ready = 1'b1;
        #1 chk("d_addr_c5", addr, 32'hFFFF_FFF8);
        nxt();
        #1 chk("d_addr_c6", addr, 32'hFFFF_FFFC);
        chk("d_valid_c6", {31'd0, valid}, 32'd0);
        nxt();
        #1 chk("d_pc_c7", pc, 32'hFFFF_FFF8);
        chk("d_addr_wrap", addr, 32'h0);
        nxt();
        #1 chk("d_pc_c8", pc, 32'hFFFF_FFFC);
        chk("d_pcp4_wrap", pcp4, 32'h0);
        chk("d_instr_c8", instr, 32'hC0DE_FFFC);
`ifdef IFETCH_PERF_EN
        chk("perf_bubble", perf_bubble, 32'd7);
        chk("perf_redir", perf_redir, 32'd1);
        chk("perf_stall", perf_stall, 32'd0);
`endif
        nxt();
        #1 chk("d_pc_c9", pc, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
